// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Shared definitions for the data cache:
//     - cache_state_e : controller FSM states
//     - DEFAULT_*     : default geometry and the widths derived from it
//     - addr_*        : address-split helpers (return zero-extended fields)
//     - line_addr     : rebuild a line-aligned byte address from tag/index
//   The helpers take field widths as arguments so one package serves any
//   legal LINE_WORDS / NUM_SETS combination.
// ---------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } cache_state_e;

    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int DEFAULT_NUM_SETS   = 16;
    localparam int DEFAULT_OFF_W      = $clog2(DEFAULT_LINE_WORDS);
    localparam int DEFAULT_IDX_W      = $clog2(DEFAULT_NUM_SETS);
    localparam int DEFAULT_TAG_W      = 32 - DEFAULT_IDX_W - DEFAULT_OFF_W - 2;

    function automatic logic [31:0] field_mask(input int width);
        field_mask = (32'd1 << width) - 32'd1;
    endfunction

    // Word offset within the line (byte bits [1:0] are dropped).
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int off_w);
        addr_offset = (addr >> 2) & field_mask(off_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int off_w,
                                               input int idx_w);
        addr_index = (addr >> (off_w + 2)) & field_mask(idx_w);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int off_w,
                                             input int idx_w);
        addr_tag = addr >> (off_w + idx_w + 2);
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                              input logic [31:0] index,
                                              input int off_w,
                                              input int idx_w);
        line_addr = (tag << (off_w + idx_w + 2)) | (index << (off_w + 2));
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// ---------------------------------------------------------------------------
// cache_line_store
//   Valid, dirty, tag and data arrays of the direct-mapped cache.
//   Reads are combinational on `index`; all writes target the same index.
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//                               (clears valid and dirty only)
//     index                   : set being read / written
//     rd_valid, rd_dirty,
//     rd_tag, rd_line         : contents of the selected set
//     fill_en, fill_tag,
//     fill_line               : install a whole line (valid=1, dirty=0)
//     word_we, word_off,
//     word_data               : overwrite one word and mark the line dirty
// ---------------------------------------------------------------------------
module cache_line_store
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int NUM_SETS   = DEFAULT_NUM_SETS,
    parameter int TAG_W      = DEFAULT_TAG_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_SETS)-1:0]  index,
    output logic                         rd_valid,
    output logic                         rd_dirty,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [32*LINE_WORDS-1:0]     rd_line,
    input  logic                         fill_en,
    input  logic [TAG_W-1:0]             fill_tag,
    input  logic [32*LINE_WORDS-1:0]     fill_line,
    input  logic                         word_we,
    input  logic [$clog2(LINE_WORDS)-1:0] word_off,
    input  logic [31:0]                  word_data
);

    localparam int LINE_W = 32 * LINE_WORDS;

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    logic [LINE_W-1:0]   line_d;
    logic                line_we;

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        line_d  = data_q[index];
        line_we = 1'b0;
        if (fill_en) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            line_d         = fill_line;
            line_we        = 1'b1;
        end else if (word_we) begin
            dirty_d[index]                 = 1'b1;
            line_d[{word_off, 5'b0} +: 32] = word_data;
            line_we                        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless while valid=0, so they are not
    // cleared on reset; writes are still suppressed during reset.
    always_ff @(posedge clk) begin
        if (!reset && line_we) begin
            data_q[index] <= line_d;
            if (fill_en) begin
                tag_q[index] <= fill_tag;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// ---------------------------------------------------------------------------
// data_cache
//   Direct-mapped, write-back, write-allocate data cache. One CPU word
//   access at a time; misses move whole lines over a memory port where the
//   request is held until a one-cycle acknowledge.
//   Handshake: the CPU request is taken on a rising edge where
//   is_input_valid=1 and is_ready=1; completion is a one-cycle
//   is_output_valid pulse carrying dout/is_hit. mem_req with mem_we/mem_addr/
//   mem_wdata is held stable until the edge on which mem_ack=1.
//   Ports:
//     clk, reset                         : clock, sync active-high reset
//     is_input_valid, addr, mem_rw, din  : CPU request (0=load, 1=store)
//     is_ready, is_output_valid, dout,
//     is_hit                             : CPU response
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_rdata, mem_ack      : line memory port
//     hit_count, miss_count              : only with DCACHE_STATS_EN defined
//   Optional feature macro: DCACHE_STATS_EN (hit/miss counters).
// ---------------------------------------------------------------------------
module data_cache
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int NUM_SETS   = DEFAULT_NUM_SETS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_input_valid,
    input  logic [31:0]               addr,
    input  logic                      mem_rw,
    input  logic [31:0]               din,
    output logic                      is_ready,
    output logic                      is_output_valid,
    output logic [31:0]               dout,
    output logic                      is_hit,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [32*LINE_WORDS-1:0]  mem_wdata,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata,
    input  logic                      mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
    localparam int LINE_W = 32 * LINE_WORDS;

    cache_state_e       state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               rw_q, rw_d;
    logic [31:0]        din_q, din_d;
    logic               first_try_q, first_try_d;

    // Incoming address split (helpers return zero-extended fields).
    logic [31:0] in_off_full, in_idx_full, in_tag_full;
    logic        unused_split_bits;

    assign in_off_full = addr_offset(addr, OFF_W);
    assign in_idx_full = addr_index(addr, OFF_W, IDX_W);
    assign in_tag_full = addr_tag(addr, OFF_W, IDX_W);
    assign unused_split_bits = ^{in_off_full[31:OFF_W], in_idx_full[31:IDX_W],
                                 in_tag_full[31:TAG_W]};

    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_line;
    logic               fill_en, word_we;
    logic               hit;
    logic [31:0]        sel_word;
    logic [31:0]        wb_addr, fill_addr;

    cache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_SETS   (NUM_SETS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .index     (index_q),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .fill_en   (fill_en),
        .fill_tag  (tag_q),
        .fill_line (mem_rdata),
        .word_we   (word_we),
        .word_off  (off_q),
        .word_data (din_q)
    );

    assign hit      = rd_valid && (rd_tag == tag_q);
    assign sel_word = rd_line[{off_q, 5'b0} +: 32];

    // Writeback goes to the victim's address (stored tag), fill to the
    // requested one. Both are steady while waiting because the set's
    // contents only change on the fill edge itself.
    assign wb_addr   = line_addr({{(32-TAG_W){1'b0}}, rd_tag},
                                 {{(32-IDX_W){1'b0}}, index_q}, OFF_W, IDX_W);
    assign fill_addr = line_addr({{(32-TAG_W){1'b0}}, tag_q},
                                 {{(32-IDX_W){1'b0}}, index_q}, OFF_W, IDX_W);

    always_comb begin
        state_d         = state_q;
        tag_d           = tag_q;
        index_d         = index_q;
        off_d           = off_q;
        rw_d            = rw_q;
        din_d           = din_q;
        first_try_d     = first_try_q;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        is_hit          = 1'b0;
        dout            = 32'd0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = 32'd0;
        mem_wdata       = '0;
        fill_en         = 1'b0;
        word_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                is_ready = 1'b1;
                if (is_input_valid) begin
                    tag_d       = in_tag_full[TAG_W-1:0];
                    index_d     = in_idx_full[IDX_W-1:0];
                    off_d       = in_off_full[OFF_W-1:0];
                    rw_d        = mem_rw;
                    din_d       = din;
                    first_try_d = 1'b1;
                    state_d     = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (hit) begin
                    is_output_valid = 1'b1;
                    is_hit          = first_try_q;
                    if (rw_q) begin
                        word_we = 1'b1;
                    end else begin
                        dout = sel_word;
                    end
                    state_d = ST_IDLE;
                end else begin
                    first_try_d = 1'b0;
                    state_d     = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_addr;
                mem_wdata = rd_line;
                if (mem_ack) begin
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ack) begin
                    fill_en = 1'b1;
                    state_d = ST_COMPARE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            index_q     <= '0;
            off_q       <= '0;
            rw_q        <= 1'b0;
            din_q       <= 32'd0;
            first_try_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            off_q       <= off_d;
            rw_q        <= rw_d;
            din_q       <= din_d;
            first_try_q <= first_try_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (is_output_valid) begin
            if (is_hit) begin
                hit_count_d = hit_count_q + 32'd1;
            end else begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// ---------------------------------------------------------------------------
// tb_data_cache
//   Drives CPU requests into data_cache, models line memory, and checks each
//   response against a word-level reference memory plus a direct-mapped
//   residency model. Build with +define+DCACHE_STATS_EN to also check the
//   hit/miss counters.
// ---------------------------------------------------------------------------
module tb_data_cache;

  localparam int LW     = 4;
  localparam int NS     = 16;
  localparam int LINE_W = 32 * LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              is_input_valid;
  logic [31:0]       addr;
  logic              mem_rw;
  logic [31:0]       din;
  logic              is_ready;
  logic              is_output_valid;
  logic [31:0]       dout;
  logic              is_hit;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;
`endif

  data_cache #(.LINE_WORDS(LW), .NUM_SETS(NS)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_rw          (mem_rw),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Initial memory image: line 0x10 holds 0x11..0x44, everything else a hash.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  init_word = 32'h11;
      32'h14:  init_word = 32'h22;
      32'h18:  init_word = 32'h33;
      32'h1C:  init_word = 32'h44;
      default: init_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  logic [31:0] word_mem [logic [31:0]];   // CPU-visible memory (last store wins)
  logic        set_valid [NS];
  logic [31:0] set_tag   [NS];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (word_mem.exists(a)) ref_read = word_mem[a];
    else ref_read = init_word(a);
  endfunction

  // ---------------- line memory model ----------------
  logic [LINE_W-1:0] line_mem [logic [31:0]];

  function automatic logic [LINE_W-1:0] fetch_line(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (line_mem.exists(la)) begin
      l = line_mem[la];
    end else begin
      for (int w = 0; w < LW; w++) l[32*w +: 32] = init_word(la + 32'(4 * w));
    end
    return l;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] w2;
  } txn_t;
  txn_t txn_log[$];

  int slow_lat = 0;

  initial begin : mem_responder
    logic              busy;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [LINE_W-1:0] c_wdata;
    logic              stable_ok;
    int                lat;
    int                wait_cnt;
    txn_t              t;
    busy      = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    c_we      = 1'b0;
    c_addr    = '0;
    c_wdata   = '0;
    stable_ok = 1'b1;
    lat       = 0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy      = 1'b1;
          c_we      = mem_we;
          c_addr    = mem_addr;
          c_wdata   = mem_wdata;
          wait_cnt  = 0;
          stable_ok = 1'b1;
          lat       = (slow_lat > 0) ? slow_lat : int'($urandom_range(0, 3));
        end else if (mem_we !== c_we || mem_addr !== c_addr || mem_wdata !== c_wdata) begin
          stable_ok = 1'b0;
        end
        if (is_ready !== 1'b0) stable_ok = 1'b0;
        if (wait_cnt == lat) begin
          mem_rdata = fetch_line(c_addr);
          if (c_we) line_mem[c_addr] = c_wdata;
          mem_ack = 1'b1;
          busy    = 1'b0;
          chk("mem_req_stable_not_ready", {31'd0, stable_ok}, 32'd1);
          chk("mem_addr_aligned", {28'd0, c_addr[3:0]}, 32'd0);
          t.we = c_we;
          t.a  = c_addr;
          t.w2 = c_wdata[95:64];
          txn_log.push_back(t);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic        is_load;
    logic [31:0] dout;
    logic        hit;
  } sb_t;
  sb_t exp_q[$];
  int unsigned acc_cyc = 0;

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && is_output_valid === 1'b1) begin
        chk("unexpected_output_valid", {31'd0, exp_q.size() == 0}, 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("is_hit", {31'd0, is_hit}, {31'd0, e.hit});
          if (e.is_load) chk("dout", dout, e.dout);
          if (e.hit) chk("hit_latency", cyc - acc_cyc, 32'd0);
          else chk("miss_latency_ge2", {31'd0, (cyc - acc_cyc) >= 2}, 32'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    word_mem.delete();
    line_mem.delete();
    for (int i = 0; i < NS; i++) set_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (is_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_timeout", {31'd0, is_ready === 1'b1}, 32'd1);
    is_input_valid = 1'b1;
    addr           = a;
    mem_rw         = rw;
    din            = d;
    @(posedge clk);
    #1;
    acc_cyc        = cyc;
    is_input_valid = 1'b0;
    addr           = $urandom;
    mem_rw         = $urandom_range(0, 1);
    din            = $urandom;
  endtask

  task automatic issue(input logic [31:0] a, input logic rw, input logic [31:0] d);
    sb_t         e;
    int unsigned idx;
    logic [31:0] tg;
    logic [31:0] wa;
    int          n;
    wa  = a & 32'hFFFF_FFFC;
    idx = (wa >> 4) & (NS - 1);
    tg  = wa >> 8;
    e.hit     = set_valid[idx] && (set_tag[idx] == tg);
    e.is_load = !rw;
    e.dout    = rw ? 32'd0 : ref_read(wa);
    set_valid[idx] = 1'b1;
    set_tag[idx]   = tg;
    if (rw) word_mem[wa] = d;
    if (e.hit) exp_hits++;
    else exp_misses++;
    exp_q.push_back(e);
    drive_req(a, rw, d);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("response_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_rw         = 1'b0;
    din            = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_is_ready", {31'd0, is_ready}, 32'd1);
    chk("rst_is_output_valid", {31'd0, is_output_valid}, 32'd0);
    chk("rst_is_hit", {31'd0, is_hit}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Cold read
    txn_log.delete();
    issue(32'h10, 1'b0, 32'd0);
    chk("cold_txn_count", txn_log.size(), 32'd1);
    if (txn_log.size() >= 1) begin
      chk("cold_mem_we", {31'd0, txn_log[0].we}, 32'd0);
      chk("cold_mem_addr", txn_log[0].a, 32'h10);
    end

    // Hit: no memory traffic
    txn_log.delete();
    issue(32'h14, 1'b0, 32'd0);
    chk("hit_no_mem_req", txn_log.size(), 32'd0);

    // Dirty eviction
    issue(32'h18, 1'b1, 32'hDEAD_BEEF);
    txn_log.delete();
    issue(32'h118, 1'b0, 32'd0);
    chk("evict_txn_count", txn_log.size(), 32'd2);
    if (txn_log.size() >= 2) begin
      chk("evict_wb_we", {31'd0, txn_log[0].we}, 32'd1);
      chk("evict_wb_addr", txn_log[0].a, 32'h10);
      chk("evict_wb_word2", txn_log[0].w2, 32'hDEAD_BEEF);
      chk("evict_fill_we", {31'd0, txn_log[1].we}, 32'd0);
      chk("evict_fill_addr", txn_log[1].a, 32'h110);
    end
    // Re-read the evicted store through memory.
    issue(32'h18, 1'b0, 32'd0);

    // Slow memory
    slow_lat = 50;
    txn_log.delete();
    issue(32'h230, 1'b0, 32'd0);
    slow_lat = 0;
    chk("slow_txn_count", txn_log.size(), 32'd1);
    repeat (3) @(negedge clk);

    // Reset during ALLOCATE
    begin
      int n;
      slow_lat = 40;
      drive_req(32'h340, 1'b0, 32'd0);
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("alloc_mem_req_seen", {31'd0, mem_req}, 32'd1);
      chk("alloc_mem_we", {31'd0, mem_we}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("midrst_is_ready", {31'd0, is_ready}, 32'd1);
      slow_lat = 0;
    end
    issue(32'h14, 1'b0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 255)) << 2);
      issue(a, 1'($urandom_range(0, 1)), $urandom);
    end

`ifdef DCACHE_STATS_EN
    chk("stats_hit_count", hit_count, exp_hits);
    chk("stats_miss_count", miss_count, exp_misses);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
